// File: rtl/tdm_demux8.sv
// tdm_demux8: time-division 1-to-N demux, serial slot stream to parallel frame word
module tdm_demux8 #(
    parameter int W    = 1,
    parameter int N_CH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              sof,
    output logic [N_CH*W-1:0] dout,
    output logic              dout_valid,
    output logic [N_CH-1:0]   slot_en,
    output logic              frame_err,
    output logic              busy
);
    localparam int SEL_W = $clog2(N_CH);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t                   state, state_nx;
    logic [SEL_W-1:0]         slot;
    logic [(N_CH-1)*W-1:0]    shadow;
    logic                     acc_sof, collecting, last;
    assign acc_sof    = din_valid & sof;
    assign collecting = state == COLLECT;
    assign last       = collecting & din_valid & ~sof & (slot == SEL_W'(N_CH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end
    always_comb begin
        state_nx = acc_sof ? COLLECT : last ? IDLE : state;
    end
    always_comb begin
        busy    = collecting;
        slot_en = (acc_sof | (collecting & din_valid)) ?
                  {{(N_CH-1){1'b0}}, 1'b1} << (acc_sof ? SEL_W'(0) : slot) : '0;
    end
    // The last slot goes straight into dout, so shadow only holds slots 0..N_CH-2
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot       <= '0;
            shadow     <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            slot       <= acc_sof ? SEL_W'(1) : last ? '0 :
                          (collecting & din_valid) ? SEL_W'(slot + 1'b1) : slot;
            for (int k = 0; k < N_CH - 1; k++)
                if (slot_en[k]) shadow[k*W +: W] <= din;
            dout       <= last ? {din, shadow} : dout;
            dout_valid <= last;
            frame_err  <= acc_sof & collecting;
        end
    end
endmodule

// File: tb/tb_tdm_demux8.sv
// tb_tdm_demux8: randomized and directed checks against a queue-based frame model
module tb_tdm_demux8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [0:0] din = '0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic [7:0] slot_en;
    logic       frame_err;
    logic       busy;
    int         checks = 0;
    int         errors = 0;
    bit         q[$];
    logic [7:0] m_dout = '0;
    bit         m_valid = 0;
    bit         m_err = 0;

    tdm_demux8 #(.W(1), .N_CH(8)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
        .dout(dout), .dout_valid(dout_valid), .slot_en(slot_en),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // A frame is a list of words started by sof; it completes when it holds 8 words
    task automatic model(input bit dv, input bit s, input bit d);
        m_valid = 0;
        m_err   = 0;
        if (dv) begin
            if (s) begin
                m_err = q.size() > 0;
                q.delete();
                q.push_back(d);
            end else if (q.size() > 0) begin
                q.push_back(d);
                if (q.size() == 8) begin
                    for (int k = 0; k < 8; k++) m_dout[k] = q[k];
                    m_valid = 1;
                    q.delete();
                end
            end
        end
    endtask

    task automatic step(input bit dv, input bit s, input bit d);
        logic [7:0] e;
        @(negedge clk);
        din_valid = dv;
        sof = s;
        din = d;
        #1;
        e = (dv && (s || q.size() > 0)) ? 8'(1) << (s ? 0 : q.size()) : 8'h00;
        chk("slot_en", slot_en, e);
        chk("busy", busy, q.size() > 0);
        @(posedge clk);
        model(dv, s, d);
        #1;
        chk("dout", dout, m_dout);
        chk("dout_valid", dout_valid, m_valid);
        chk("frame_err", frame_err, m_err);
    endtask

    task automatic send_frame(input logic [7:0] b);
        for (int k = 0; k < 8; k++) step(1, k == 0, b[k]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        din_valid = 0;
        sof = 0;
        #2 rst = 1;
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_slot_en", slot_en, 0);
        q.delete();
        m_dout = '0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        #1;
        chk("init_dout", dout, 0);
        chk("init_busy", busy, 0);
        @(negedge clk);
        rst = 0;
        send_frame(8'h4D);
        chk("t1_dout", dout, 8'h4D);
        for (int k = 0; k < 8; k++) begin
            step(1, k == 0, k[0] ? 1'b0 : 1'b1);
        end
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b = 8'h4D;
            step(1, k == 0, b[k]);
            if (k == 4) repeat (3) step(0, 0, 1);
        end
        chk("t2_dout", dout, 8'h4D);
        send_frame(8'h4D);
        send_frame(8'hB2);
        chk("t3_dout", dout, 8'hB2);
        for (int k = 0; k < 5; k++) step(1, k == 0, 1);
        send_frame(8'hFF);
        chk("t4_dout", dout, 8'hFF);
        do_reset();
        repeat (3) step(1, 0, 1);
        chk("t5_dout", dout, 0);
        send_frame(8'hB2);
        for (int k = 0; k < 4; k++) step(1, k == 0, 1);
        do_reset();
        send_frame(8'h01);
        chk("t6_dout", dout, 8'h01);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(3) != 0, $urandom_range(11) == 0, 1'($urandom));
        for (int i = 0; i < 20; i++) send_frame(8'($urandom));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
